syscall_unit: RTL and testbench
===============================

Name: syscall_unit

Overview:
- Reader-side companion to the register file: services the SYSCALL instruction by reading $v0/$a0 through a borrowed register-file read port.
- Performs the requested service: print signed integer as decimal ASCII, print char, or exit.
- Stalls the single-cycle datapath until the service completes.
- Sits beside the control unit; its byte stream feeds the console/UART transmitter via valid/ready.

Parameters:
- V0_ADDR, 5'd2, register index holding the syscall code.
- A0_ADDR, 5'd4, register index holding the argument.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- syscall  in  1  decoded SYSCALL instruction present this cycle
- stall  out  1  hold PC and suppress writes while high
- rf_read_en  out  1  top level muxes rf_read_addr onto register-file read_reg1 when high
- rf_read_addr  out  5  register index to read
- rf_read_data  in  32  combinational read_data1 from the register file
- tx_data  out  8  ASCII byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  consumer accepts byte
- halt  out  1  sticky; exit requested
- bad_code  out  1  one-cycle pulse; unsupported code
- bad_code_value  out  32  offending $v0 value, valid with bad_code

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-operation aborts immediately with no partial byte held; tx_valid drops the cycle after rst is sampled.
- stall = (state != IDLE && state != DONE) || (state == IDLE && syscall). This is combinational, so the SYSCALL cycle itself stalls.
- IDLE: if syscall, drive rf_read_en=1 and rf_read_addr=V0_ADDR, latch code, go to RD_A0.
- RD_A0: rf_read_en=1, rf_read_addr=A0_ADDR; latch arg; go to DISPATCH.
- DISPATCH, by code:
  - code 1: if arg[31], load mag=-arg and go to SIGN; else mag=arg and go to CONV. In both cases idx=9 and started=0.
  - code 11: load tx byte = arg[7:0], mode=CHAR, go to EMIT.
  - code 10: go to HALT.
  - other codes: pulse bad_code with bad_code_value=code, go to DONE.
- SIGN: load byte 0x2D ('-'), mode=SIGN, go to EMIT.
- CONV: repeated subtraction against POW10[idx], which spans 10^9 down to 10^0.
  - If mag >= POW10[idx]: mag -= POW10[idx], digit++ (at most 9 per idx).
  - Else digit is final. If digit != 0, started, or idx == 0: load byte 0x30+digit, set started=1, mode=DIGIT, go to EMIT. Otherwise idx--, digit=0, stay.
- Magnitude is 32-bit unsigned, so -2^31 yields 2147483648 correctly.
- EMIT: tx_valid=1 with tx_data stable until the cycle tx_valid && tx_ready, which is the transfer cycle. Then:
  - mode CHAR: go to DONE.
  - mode SIGN: go to CONV.
  - mode DIGIT: if idx == 0 go to DONE, else idx--, digit=0, go to CONV.
- DONE: stall=0 for exactly one cycle so the PC advances. syscall is ignored in DONE because it is the same instruction. Go to IDLE.
- HALT: halt=1 and stall=1, sticky until rst. No further service.
- No newline is appended to printed integers.
- A back-to-back SYSCALL on the cycle after DONE is serviced normally.

Decomposition:
- Shared package mips_syscall_pkg holds:
  - SYS_PRINT_INT=1, SYS_EXIT=10, SYS_PRINT_CHAR=11
  - state enum {IDLE, RD_A0, DISPATCH, SIGN, CONV, EMIT, DONE, HALT}
  - emit-mode enum {CHAR, SIGN, DIGIT}
  - POW10 constant table (10 x 32-bit)
- One natural sub-module, syscall_digit_gen, holds mag/idx/digit/started and the subtraction step. It exposes load, step, digit_ready, digit, last.

Test Plan:
- $v0=1, $a0=0, tx_ready=1 -> single byte 0x30.
  - stall high from the SYSCALL cycle through the transfer; DONE cycle has stall=0; PC advances once.
- $v0=1, $a0=1234 -> bytes 0x31,0x32,0x33,0x34 in order; no leading zeros; rf_read_addr shows 2 then 4.
- $v0=1, $a0=0x80000000 -> "-2147483648" (11 bytes, first 0x2D).
- $v0=11, $a0=0x141, tx_ready low for 5 cycles:
  - tx_valid held with tx_data=0x41 stable for all 5 cycles.
  - Single transfer once ready rises.
- $v0=10 -> halt=1 and stall=1 from DISPATCH+1 onward, persisting 100 cycles.
- $v0=7 -> bad_code one-cycle pulse with bad_code_value=7, no tx_valid, return to IDLE.
- rst asserted mid-digit during print of 98765 -> next cycle all outputs 0, state IDLE; a new SYSCALL then prints correctly.

Source files
------------

// File: rtl/mips_syscall_pkg.sv
// Shared definitions for the SYSCALL service unit: service codes, FSM
// states, emit modes and the decimal place-value table.
package mips_syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A0,
    ST_DISPATCH,
    ST_SIGN,
    ST_CONV,
    ST_EMIT,
    ST_DONE,
    ST_HALT
  } state_t;

  // What the byte currently in EMIT represents, which decides where to go after it is sent.
  typedef enum logic [1:0] {
    MODE_CHAR,
    MODE_SIGN,
    MODE_DIGIT
  } mode_t;

  // POW10[i] = 10^i; the converter walks i from 9 down to 0.
  localparam logic [9:0][31:0] POW10 = {
    32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
    32'd10000,      32'd1000,      32'd100,      32'd10,      32'd1
  };

endpackage

// File: rtl/syscall_digit_gen.sv
// Binary-to-decimal digit generator using repeated subtraction of powers
// of ten, most significant place first, with leading-zero suppression.
module syscall_digit_gen
  import mips_syscall_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] mag_in,
  input  logic        step,
  input  logic        advance,
  output logic        digit_ready,
  output logic [3:0]  digit,
  output logic        last
);

  logic [31:0] mag_q;
  logic [3:0]  idx_q;
  logic [3:0]  digit_q;
  logic        started_q;
  logic [31:0] pow;
  logic        ge;

  assign pow = POW10[idx_q];
  assign ge  = (mag_q >= pow);

  // A digit is final once the place value no longer fits; it is printed unless it is a leading zero.
  assign digit_ready = !ge && ((digit_q != 4'd0) || started_q || (idx_q == 4'd0));
  assign digit       = digit_q;
  assign last        = (idx_q == 4'd0);

  // Conversion state: load a fresh magnitude, subtract one place value per step, move to the next place after emission.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values, regardless of statement order.
    if (rst) begin
      mag_q     <= '0;
      idx_q     <= '0;
      digit_q   <= '0;
      started_q <= 1'b0;
    end else if (load) begin
      mag_q     <= mag_in;
      idx_q     <= 4'd9;
      digit_q   <= '0;
      started_q <= 1'b0;
    end else if (step) begin
      if (ge) begin
        mag_q   <= mag_q - pow;
        digit_q <= digit_q + 4'd1;
      end else if (digit_ready) begin
        started_q <= 1'b1;
      end else begin
        idx_q   <= idx_q - 4'd1;
        digit_q <= '0;
      end
    end else if (advance) begin
      idx_q   <= idx_q - 4'd1;
      digit_q <= '0;
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// SYSCALL service unit: reads $v0/$a0 through a borrowed register-file
// port, then prints a signed integer or a character, or halts, stalling
// the datapath until the service is finished.
module syscall_unit
  import mips_syscall_pkg::*;
#(
  parameter logic [4:0] V0_ADDR = 5'd2,
  parameter logic [4:0] A0_ADDR = 5'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  output logic        stall,
  output logic        rf_read_en,
  output logic [4:0]  rf_read_addr,
  input  logic [31:0] rf_read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt,
  output logic        bad_code,
  output logic [31:0] bad_code_value
);

  state_t      state, state_nx;
  mode_t       mode_q;
  logic [31:0] code_q;
  logic [31:0] arg_q;
  logic [7:0]  byte_q;

  logic        gen_load, gen_step, gen_advance;
  logic        gen_ready, gen_last;
  logic [3:0]  gen_digit;
  logic [31:0] gen_mag_in;
  logic        xfer;

  assign xfer = (state == ST_EMIT) && tx_ready;

  syscall_digit_gen u_digit_gen (
    .clk         (clk),
    .rst         (rst),
    .load        (gen_load),
    .mag_in      (gen_mag_in),
    .step        (gen_step),
    .advance     (gen_advance),
    .digit_ready (gen_ready),
    .digit       (gen_digit),
    .last        (gen_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Operand capture and the byte staged for transmission.
  always_ff @(posedge clk) begin
    // NOTE: the staged byte is cleared on reset so an aborted print leaves nothing behind to resurface later.
    if (rst) begin
      code_q <= '0;
      arg_q  <= '0;
      byte_q <= '0;
      mode_q <= MODE_CHAR;
    end else begin
      case (state)
        ST_IDLE:  if (syscall) code_q <= rf_read_data;
        ST_RD_A0: arg_q <= rf_read_data;
        ST_DISPATCH: begin
          if (code_q == SYS_PRINT_CHAR) begin
            byte_q <= arg_q[7:0];
            mode_q <= MODE_CHAR;
          end
        end
        ST_SIGN: begin
          byte_q <= 8'h2D;
          mode_q <= MODE_SIGN;
        end
        ST_CONV: begin
          if (gen_ready) begin
            byte_q <= 8'h30 + {4'd0, gen_digit};
            mode_q <= MODE_DIGIT;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default first means every path assigns state_nx, so no latch is inferred.
    state_nx = state;
    case (state)
      ST_IDLE:  if (syscall) state_nx = ST_RD_A0;
      ST_RD_A0: state_nx = ST_DISPATCH;
      ST_DISPATCH: begin
        case (code_q)
          SYS_PRINT_INT:  state_nx = arg_q[31] ? ST_SIGN : ST_CONV;
          SYS_PRINT_CHAR: state_nx = ST_EMIT;
          SYS_EXIT:       state_nx = ST_HALT;
          default:        state_nx = ST_DONE;
        endcase
      end
      ST_SIGN: state_nx = ST_EMIT;
      ST_CONV: if (gen_ready) state_nx = ST_EMIT;
      ST_EMIT: begin
        if (tx_ready) begin
          case (mode_q)
            MODE_SIGN:  state_nx = ST_CONV;
            MODE_DIGIT: state_nx = gen_last ? ST_DONE : ST_CONV;
            default:    state_nx = ST_DONE;
          endcase
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs and digit-generator controls decoded from the current state.
  always_comb begin
    stall          = 1'b0;
    rf_read_en     = 1'b0;
    rf_read_addr   = '0;
    tx_valid       = 1'b0;
    tx_data        = '0;
    halt           = 1'b0;
    bad_code       = 1'b0;
    bad_code_value = '0;
    gen_load       = 1'b0;
    gen_step       = 1'b0;
    gen_advance    = 1'b0;
    gen_mag_in     = arg_q[31] ? (32'd0 - arg_q) : arg_q;
    case (state)
      ST_IDLE: begin
        if (syscall) begin
          stall        = 1'b1;
          rf_read_en   = 1'b1;
          rf_read_addr = V0_ADDR;
        end
      end
      ST_RD_A0: begin
        stall        = 1'b1;
        rf_read_en   = 1'b1;
        rf_read_addr = A0_ADDR;
      end
      ST_DISPATCH: begin
        stall    = 1'b1;
        gen_load = (code_q == SYS_PRINT_INT);
        if ((code_q != SYS_PRINT_INT) && (code_q != SYS_PRINT_CHAR) && (code_q != SYS_EXIT)) begin
          bad_code       = 1'b1;
          bad_code_value = code_q;
        end
      end
      ST_SIGN: stall = 1'b1;
      ST_CONV: begin
        stall    = 1'b1;
        gen_step = 1'b1;
      end
      ST_EMIT: begin
        stall       = 1'b1;
        tx_valid    = 1'b1;
        tx_data     = byte_q;
        gen_advance = xfer && (mode_q == MODE_DIGIT) && !gen_last;
      end
      ST_HALT: begin
        stall = 1'b1;
        halt  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: a driver issues SYSCALLs against a
// modelled register file and pushes the expected console bytes; a monitor
// pops and compares whenever a byte transfers or bad_code fires.
module tb_syscall_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        syscall;
  logic        stall;
  logic        rf_read_en;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;
  logic        bad_code;
  logic [31:0] bad_code_value;

  logic [31:0] regs [32];
  logic [7:0]  tx_q [$];
  logic [31:0] bad_q [$];

  int checks   = 0;
  int failures = 0;
  int xfers    = 0;
  int start, bad_cnt;

  // Sentinel meaning "the monitor expected nothing here"; no real byte or code can equal it.
  localparam logic [63:0] NONE = 64'hFFFF_FFFF_FFFF_FFFF;

  syscall_unit dut (
    .clk            (clk),
    .rst            (rst),
    .syscall        (syscall),
    .stall          (stall),
    .rf_read_en     (rf_read_en),
    .rf_read_addr   (rf_read_addr),
    .rf_read_data   (rf_read_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .halt           (halt),
    .bad_code       (bad_code),
    .bad_code_value (bad_code_value)
  );

  always #5 clk = ~clk;

  assign rf_read_data = rf_read_en ? regs[rf_read_addr] : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(s[i]);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_rf_en"}, rf_read_en, 0);
    check({tag, "_rf_addr"}, rf_read_addr, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_halt"}, halt, 0);
    check({tag, "_bad"}, bad_code, 0);
    check({tag, "_bad_val"}, bad_code_value, 0);
  endtask

  // Monitor: compare every transferred byte and every bad_code pulse against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        xfers++;
        check("tx_byte", {56'd0, tx_data}, (tx_q.size() > 0) ? {56'd0, tx_q.pop_front()} : NONE);
      end
      if (bad_code)
        check("bad_code_value", {32'd0, bad_code_value}, (bad_q.size() > 0) ? {32'd0, bad_q.pop_front()} : NONE);
    end
  end

  // One complete SYSCALL: holds syscall high until the PC-advance cycle (stall low), optionally holding tx_ready low.
  task automatic run_op(input logic [31:0] v0, input logic [31:0] a0, input int n_bytes,
                        input int hold, input logic [7:0] hold_byte);
    int  s, held;
    bit  done;
    s = xfers; held = 0; done = 0;
    regs[2] = v0; regs[4] = a0;
    tx_ready = (hold == 0);
    @(posedge clk); #1 syscall = 1'b1;
    @(negedge clk); #1;
    check("sys_cycle_stall", stall, 1);
    check("rd_v0_en", rf_read_en, 1);
    check("rd_v0_addr", rf_read_addr, 2);
    @(negedge clk); #1;
    check("rd_a0_en", rf_read_en, 1);
    check("rd_a0_addr", rf_read_addr, 4);
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk); #1;
      if (!stall) done = 1;
      else if (tx_valid && !tx_ready) begin
        check("hold_data", tx_data, hold_byte);
        held++;
        if (held == hold) begin
          @(posedge clk); #1 tx_ready = 1'b1;
        end
      end
    end
    check("done_reached", done, 1);
    check("bytes_before_done", xfers - s, n_bytes);
    check("done_no_valid", tx_valid, 0);
    check("hold_cycles", held, hold);
    @(posedge clk); #1 syscall = 1'b0; tx_ready = 1'b1;
    @(negedge clk); #1;
    check("idle_after_done", stall, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = '0;
    rst = 1'b1; syscall = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check_quiet("reset");

    // Zero prints a single '0'.
    push_str("0");
    run_op(32'd1, 32'd0, 1, 0, 8'h00);

    // No leading zeros.
    push_str("1234");
    run_op(32'd1, 32'd1234, 4, 0, 8'h00);

    // Most negative value: magnitude 2^31 must survive as unsigned.
    push_str("-2147483648");
    run_op(32'd1, 32'h8000_0000, 11, 0, 8'h00);

    // Character with back-pressure: only the low byte of $a0 is printed.
    push_str("A");
    run_op(32'd11, 32'h0000_0141, 1, 5, 8'h41);

    // Unsupported code: one bad_code pulse, no bytes.
    bad_q.push_back(32'd7);
    run_op(32'd7, 32'd99, 0, 0, 8'h00);

    // Reset in the middle of printing 98765, while '7' is waiting in EMIT.
    push_str("98");
    start = xfers;
    regs[2] = 32'd1; regs[4] = 32'd98765;
    @(posedge clk); #1 syscall = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk); #1;
      if (xfers - start == 2) break;
    end
    check("mid_two_bytes", xfers - start, 2);
    @(posedge clk); #1 tx_ready = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (tx_valid) break;
    end
    check("mid_valid", tx_valid, 1);
    check("mid_data", tx_data, 8'h37);
    @(posedge clk); #1 rst = 1'b1; syscall = 1'b0;
    @(posedge clk); #1 rst = 1'b0; tx_ready = 1'b1;
    @(negedge clk); #1;
    check_quiet("mid_reset");

    push_str("98765");
    run_op(32'd1, 32'd98765, 5, 0, 8'h00);

    // Exit: halt and stall from the cycle after DISPATCH, held indefinitely.
    regs[2] = 32'd10; regs[4] = 32'd0;
    @(posedge clk); #1 syscall = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("halt_not_in_dispatch", halt, 0);
    @(negedge clk); #1;
    check("halt_set", halt, 1);
    check("halt_stall", stall, 1);
    bad_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (!halt || !stall || tx_valid) bad_cnt++;
    end
    check("halt_persist_bad_cycles", bad_cnt, 0);
    @(posedge clk); #1 rst = 1'b1; syscall = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check_quiet("halt_reset");

    check("tx_q_left", tx_q.size(), 0);
    check("bad_q_left", bad_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
